neuron_multi_level_input: RTL and testbench

NEURON_MULTI_LEVEL_INPUT -- requirements
Module: neuron_multi_level_input

---
 rtl/neuron_multi_level_input.sv | 203 ++++++++++++++++++++
 tb/tb_neuron_multi_level_input.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_multi_level_input.sv
// Multi-level row driver: loads signed 7-bit row magnitudes, then replays them as
// per-phase SPI enable frames and input pulses. Define NMLI_EARLY_STOP_EN for early stop.
module neuron_multi_level_input #(
    parameter int unsigned spi_length = 384
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_trigger,
    input  logic                  input_trigger,
    output logic                  idle,
    input  logic [31:0]           pipe_in,
    input  logic                  pipe_in_valid,
    output logic                  pipe_in_ready,
    input  logic                  spi_idle,
    input  logic                  neuron_idle,
    output logic [spi_length-1:0] spi_output,
    output logic                  polarity,
    output logic                  spi_write_trigger,
    output logic                  pulse_trigger
);
    localparam int unsigned words  = spi_length / 4;
    localparam int unsigned word_w = (words > 1) ? $clog2(words) : 1;
    localparam int unsigned mag_w  = 7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BUILD,
        SPI_TRIG,
        SPI_WAIT,
        PULSE_TRIG,
        PULSE_WAIT,
        NEXT
    } state_t;

    state_t                  state;
    logic [word_w-1:0]       word_cnt;
    logic [1:0]              burst_cnt;
    logic [mag_w-1:0]        phase;
    logic [mag_w-1:0]        mag [spi_length];
    logic [spi_length-1:0]   sign;
    logic [mag_w-1:0]        pass_len;
    logic [spi_length-1:0]   frame;
    logic                    xfer;
    logic                    last_word;

    assign xfer      = (state == LOAD) && pipe_in_valid && pipe_in_ready;
    assign last_word = (word_cnt == word_w'(words - 1));

    // Row enables for the current phase and polarity.
    always_comb begin
        frame = '0;
        for (int r = 0; r < spi_length; r++) begin
            frame[r] = (mag[r] > phase) && (sign[r] == polarity);
        end
    end

`ifdef NMLI_EARLY_STOP_EN
    logic [mag_w-1:0] max_pos;
    logic [mag_w-1:0] max_neg;
    logic [mag_w-1:0] word_max_pos;
    logic [mag_w-1:0] word_max_neg;

    // Running per-sign maximum including the word currently on pipe_in.
    always_comb begin
        word_max_pos = max_pos;
        word_max_neg = max_neg;
        for (int j = 0; j < 4; j++) begin
            if (pipe_in[j*8 + 7]) begin
                if (pipe_in[j*8 +: mag_w] > word_max_neg) word_max_neg = pipe_in[j*8 +: mag_w];
            end else begin
                if (pipe_in[j*8 +: mag_w] > word_max_pos) word_max_pos = pipe_in[j*8 +: mag_w];
            end
        end
    end

    assign pass_len = polarity ? max_neg : max_pos;
`else
    assign pass_len = mag_w'(127);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            word_cnt          <= '0;
            burst_cnt         <= '0;
            phase             <= '0;
            polarity          <= 1'b0;
            spi_output        <= '0;
            idle              <= 1'b0;
            pipe_in_ready     <= 1'b0;
            spi_write_trigger <= 1'b0;
            pulse_trigger     <= 1'b0;
            sign              <= '0;
            for (int r = 0; r < spi_length; r++) begin
                mag[r] <= '0;
            end
`ifdef NMLI_EARLY_STOP_EN
            max_pos <= '0;
            max_neg <= '0;
`endif
        end else begin
            // Outputs follow the state one cycle later; ready drops with the last word.
            idle              <= (state == IDLE);
            pipe_in_ready     <= (state == LOAD) && !(xfer && last_word);
            spi_write_trigger <= (state == SPI_TRIG);
            pulse_trigger     <= (state == PULSE_TRIG);

            case (state)
                IDLE: begin
                    polarity  <= 1'b0;
                    phase     <= '0;
                    burst_cnt <= '0;
                    if (load_trigger) begin
                        word_cnt <= '0;
`ifdef NMLI_EARLY_STOP_EN
                        max_pos <= '0;
                        max_neg <= '0;
`endif
                        state <= LOAD;
                    end else if (input_trigger) begin
                        state <= BUILD;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        for (int j = 0; j < 4; j++) begin
                            mag[{word_cnt, 2'(j)}]  <= pipe_in[j*8 +: mag_w];
                            sign[{word_cnt, 2'(j)}] <= pipe_in[j*8 + 7];
                        end
`ifdef NMLI_EARLY_STOP_EN
                        max_pos <= word_max_pos;
                        max_neg <= word_max_neg;
`endif
                        if (last_word) begin
                            word_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            word_cnt <= word_cnt + word_w'(1);
                        end
                    end
                end
                BUILD: begin
                    spi_output <= frame;
                    burst_cnt  <= '0;
`ifdef NMLI_EARLY_STOP_EN
                    // An empty pass is skipped without any trigger.
                    if (pass_len == '0) begin
                        if (!polarity && (max_neg != '0)) begin
                            polarity <= 1'b1;
                            phase    <= '0;
                        end else begin
                            polarity <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        state <= SPI_TRIG;
                    end
`else
                    state <= SPI_TRIG;
`endif
                end
                SPI_TRIG: begin
                    if (burst_cnt == 2'd3) begin
                        burst_cnt <= '0;
                        state     <= SPI_WAIT;
                    end else begin
                        burst_cnt <= burst_cnt + 2'd1;
                    end
                end
                SPI_WAIT: begin
                    if (spi_idle) state <= PULSE_TRIG;
                end
                PULSE_TRIG: begin
                    if (burst_cnt == 2'd3) begin
                        burst_cnt <= '0;
                        state     <= PULSE_WAIT;
                    end else begin
                        burst_cnt <= burst_cnt + 2'd1;
                    end
                end
                PULSE_WAIT: begin
                    if (neuron_idle) state <= NEXT;
                end
                NEXT: begin
                    if (({1'b0, phase} + 8'd1) < {1'b0, pass_len}) begin
                        phase <= phase + mag_w'(1);
                        state <= BUILD;
                    end else if (!polarity) begin
                        polarity <= 1'b1;
                        phase    <= '0;
                        state    <= BUILD;
                    end else begin
                        polarity <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_multi_level_input.sv
// Self-checking bench for neuron_multi_level_input: frame-level model plus directed scenarios.
module tb_neuron_multi_level_input;
    localparam int SPI_LEN   = 384;
    localparam int WORDS     = SPI_LEN / 4;
    localparam int RUN_BOUND = 20000;
`ifdef NMLI_EARLY_STOP_EN
    localparam int DEMO_BURSTS = 5;
    localparam int NEG_BURSTS  = 3;
    localparam logic [SPI_LEN-1:0] DEMO_LAST = SPI_LEN'(8);
`else
    localparam int DEMO_BURSTS = 254;
    localparam int NEG_BURSTS  = 254;
    localparam logic [SPI_LEN-1:0] DEMO_LAST = '0;
`endif
    localparam logic [SPI_LEN-1:0] DEMO_FIRST = SPI_LEN'(7);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               load_trigger = 1'b0;
    logic               input_trigger = 1'b0;
    logic               idle;
    logic [31:0]        pipe_in = '0;
    logic               pipe_in_valid = 1'b0;
    logic               pipe_in_ready;
    logic               spi_idle = 1'b1;
    logic               neuron_idle = 1'b1;
    logic [SPI_LEN-1:0] spi_output;
    logic               polarity;
    logic               spi_write_trigger;
    logic               pulse_trigger;

    int errors = 0;
    int checks = 0;

    int                 mag_m [SPI_LEN];
    bit                 sign_m [SPI_LEN];
    logic [31:0]        load_data [WORDS];
    logic [SPI_LEN-1:0] exp_frames [$];
    bit                 exp_pols [$];
    int                 writes = 0;
    int                 pulses = 0;
    int                 handshakes = 0;
    int                 sw_w = 0;
    int                 pt_w = 0;
    logic [SPI_LEN-1:0] first_frame;
    logic [SPI_LEN-1:0] last_frame;
    logic [SPI_LEN-1:0] mon_f;
    bit                 mon_p;

    always #5 clk = ~clk;

    neuron_multi_level_input #(.spi_length(SPI_LEN)) dut (
        .clk               (clk),
        .rst               (rst),
        .load_trigger      (load_trigger),
        .input_trigger     (input_trigger),
        .idle              (idle),
        .pipe_in           (pipe_in),
        .pipe_in_valid     (pipe_in_valid),
        .pipe_in_ready     (pipe_in_ready),
        .spi_idle          (spi_idle),
        .neuron_idle       (neuron_idle),
        .spi_output        (spi_output),
        .polarity          (polarity),
        .spi_write_trigger (spi_write_trigger),
        .pulse_trigger     (pulse_trigger)
    );

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic check_vec(input string name, input logic [SPI_LEN-1:0] act, input logic [SPI_LEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Model: a pass lasts as long as the largest magnitude of its sign (or 127 fixed).
    function automatic int pass_len(input bit pol);
`ifdef NMLI_EARLY_STOP_EN
        int m = 0;
        for (int r = 0; r < SPI_LEN; r++) if (sign_m[r] == pol && mag_m[r] > m) m = mag_m[r];
        return m;
`else
        return (pol == pol) ? 127 : 127;
`endif
    endfunction

    function automatic logic [SPI_LEN-1:0] frame_of(input int ph, input bit pol);
        logic [SPI_LEN-1:0] f = '0;
        for (int r = 0; r < SPI_LEN; r++) f[r] = (mag_m[r] > ph) && (sign_m[r] == pol);
        return f;
    endfunction

    task automatic queue_run(output int n);
        n = 0;
        for (int p = 0; p < 2; p++) begin
            int pl;
            pl = pass_len(p != 0);
            for (int ph = 0; ph < pl; ph++) begin
                exp_frames.push_back(frame_of(ph, p != 0));
                exp_pols.push_back(p != 0);
                n++;
            end
        end
    endtask

    // Frame/trigger monitor: every SPI write is checked against the model queue.
    always @(negedge clk) begin
        if (rst) begin
            sw_w = 0;
            pt_w = 0;
        end else begin
            if (spi_write_trigger) begin
                if (sw_w == 0) begin
                    writes++;
                    checks++;
                    if (exp_frames.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: got a write, want none");
                    end else begin
                        mon_f = exp_frames.pop_front();
                        mon_p = exp_pols.pop_front();
                        check_vec("frame", spi_output, mon_f);
                        check_int("frame_polarity", int'(polarity), int'(mon_p));
                        if (writes == 1) first_frame = spi_output;
                        last_frame = spi_output;
                    end
                end
                sw_w++;
            end else if (sw_w != 0) begin
                check_int("write_width", sw_w, 4);
                sw_w = 0;
            end
            if (pulse_trigger) begin
                if (pt_w == 0) pulses++;
                pt_w++;
            end else if (pt_w != 0) begin
                check_int("pulse_width", pt_w, 4);
                pt_w = 0;
            end
            if (pipe_in_valid && pipe_in_ready) handshakes++;
        end
    end

    task automatic do_load(input bit both_triggers, input bit toggle);
        int w;
        int guard;
        int hs0;
        hs0    = handshakes;
        writes = 0;
        @(posedge clk); #1;
        load_trigger  = 1'b1;
        input_trigger = both_triggers;
        @(posedge clk); #1;
        load_trigger  = 1'b0;
        input_trigger = 1'b0;
        w = 0;
        guard = 0;
        while (w < WORDS && guard < 1000) begin
            pipe_in_valid = toggle ? ((guard % 2) == 1) : 1'b1;
            pipe_in       = load_data[w];
            @(negedge clk);
            if (pipe_in_valid && pipe_in_ready) w++;
            @(posedge clk); #1;
            guard++;
        end
        check_int("load_finished", int'(guard < 1000), 1);
        // Keep offering junk to prove nothing further is accepted.
        pipe_in       = '1;
        pipe_in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        pipe_in_valid = 1'b0;
        pipe_in       = '0;
        @(posedge clk); #1;
        check_int("load_words", handshakes - hs0, WORDS);
        check_int("load_idle", int'(idle), 1);
        check_int("load_no_write", writes, 0);
        for (int k = 0; k < WORDS; k++) begin
            for (int j = 0; j < 4; j++) begin
                mag_m[4*k + j]  = int'(load_data[k][j*8 +: 7]);
                sign_m[4*k + j] = load_data[k][j*8 + 7];
            end
        end
    endtask

    task automatic do_run(input int hold, output int nbursts, output int wait_cyc);
        int cyc;
        int held;
        queue_run(nbursts);
        writes = 0;
        pulses = 0;
        spi_idle = (hold == 0);
        @(posedge clk); #1 input_trigger = 1'b1;
        @(posedge clk); #1 input_trigger = 1'b0;
        if (hold > 0) begin
            cyc = 0;
            while ((writes == 0 || spi_write_trigger) && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
            end
            check_int("hold_reach_wait", int'(cyc < 100), 1);
            held = 0;
            repeat (hold) begin
                @(posedge clk); #1;
                if (pulse_trigger || spi_write_trigger) held++;
            end
            check_int("hold_no_trigger", held, 0);
            check_int("hold_busy", int'(idle), 0);
            spi_idle = 1'b1;
        end else begin
            repeat (3) @(posedge clk);
            #1;
        end
        wait_cyc = 0;
        while (!idle && wait_cyc < RUN_BOUND) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        check_int("run_done", int'(wait_cyc < RUN_BOUND), 1);
        check_int("run_writes", writes, nbursts);
        check_int("run_pulses", pulses, nbursts);
        check_int("run_queue_left", exp_frames.size(), 0);
        check_int("idle_polarity", int'(polarity), 0);
        exp_frames.delete();
        exp_pols.delete();
    endtask

    task automatic set_demo();
        for (int k = 0; k < WORDS; k++) load_data[k] = '0;
        load_data[0] = 32'h8203_0102;
    endtask

    initial begin
        int nb;
        int wc;
        int cyc;
        int tmp;
        for (int r = 0; r < SPI_LEN; r++) begin
            mag_m[r]  = 0;
            sign_m[r] = 1'b0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_int("rst_idle", int'(idle), 0);
        check_int("rst_ready", int'(pipe_in_ready), 0);
        check_int("rst_spi_trig", int'(spi_write_trigger), 0);
        check_int("rst_pulse_trig", int'(pulse_trigger), 0);
        check_int("rst_polarity", int'(polarity), 0);
        check_vec("rst_spi_output", spi_output, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_int("idle_after_rst", int'(idle), 1);

        // Both triggers together with a gappy valid: load wins
        set_demo();
        do_load(1'b1, 1'b1);

        // Demo pattern
        do_run(0, nb, wc);
        check_int("demo_bursts", pulses, DEMO_BURSTS);
        check_vec("demo_first_frame", first_frame, DEMO_FIRST);
        check_vec("demo_last_frame", last_frame, DEMO_LAST);

        // SPI engine busy for 50 cycles after the first write
        do_run(50, nb, wc);
        check_int("hold_bursts", pulses, DEMO_BURSTS);

        // Dense mixed-sign pattern
        for (int k = 0; k < WORDS; k++) begin
            for (int j = 0; j < 4; j++) begin
                tmp = (4*k + j) * 53 + 11;
                load_data[k][j*8 +: 8] = 8'(tmp);
            end
        end
        do_load(1'b0, 1'b0);
        do_run(0, nb, wc);

        // Negative-only rows, magnitude 3
        for (int k = 0; k < WORDS; k++) load_data[k] = 32'h8383_8383;
        do_load(1'b0, 1'b0);
        do_run(0, nb, wc);
        check_int("neg_bursts", pulses, NEG_BURSTS);

        // Reset during the third pulse
        set_demo();
        do_load(1'b0, 1'b0);
        queue_run(nb);
        writes = 0;
        pulses = 0;
        @(posedge clk); #1 input_trigger = 1'b1;
        @(posedge clk); #1 input_trigger = 1'b0;
        cyc = 0;
        while (!(pulses >= 3 && pulse_trigger) && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_int("third_pulse_seen", int'(cyc < 1000), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_int("midrst_idle", int'(idle), 0);
        check_int("midrst_ready", int'(pipe_in_ready), 0);
        check_int("midrst_spi_trig", int'(spi_write_trigger), 0);
        check_int("midrst_pulse_trig", int'(pulse_trigger), 0);
        check_int("midrst_polarity", int'(polarity), 0);
        check_vec("midrst_spi_output", spi_output, '0);
        rst = 1'b0;
        exp_frames.delete();
        exp_pols.delete();
        for (int r = 0; r < SPI_LEN; r++) begin
            mag_m[r]  = 0;
            sign_m[r] = 1'b0;
        end
        @(posedge clk); #1;
        check_int("midrst_idle_rise", int'(idle), 1);

        // Trigger after reset: stored values are cleared
        do_run(0, nb, wc);
`ifdef NMLI_EARLY_STOP_EN
        check_int("empty_writes", writes, 0);
        check_int("empty_idle_wait", wc, 0);
`else
        check_int("empty_writes", writes, 254);
        check_vec("empty_first_frame", first_frame, '0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
